dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the single-port data memory.
//  Port 0 is the pipeline MEM stage; port 1 is a DMA/debug master.
//  A grant covers a burst of 1..2^LEN_W word beats. Beat addresses auto-increment by 4.
//  Drives the memory's combinational-read / posedge-write interface and returns registered read data.
// PARAMETERS
//  DATA_W   32  data width (memory word)
//  ADDR_W   32  byte address width
//  LEN_W    4   burst length field width; beats = len+1 (1..16)
//  PRIO_FIX 0   0: round-robin; 1: port 0 always wins simultaneous requests
// PORTS  (N = 0,1; one set per requester)
//  clk          in   1       clock, all state on posedge
//  rst          in   1       synchronous, active-low reset
//  rN_req       in   1       request; sampled only in IDLE
//  rN_we        in   1       1 = write burst, 0 = read burst
//  rN_addr      in   ADDR_W  burst start byte address; bits [1:0] ignored
//  rN_len       in   LEN_W   beats-1
//  rN_wdata     in   DATA_W  write data for the current beat; must be valid while rN_ack=1
//  rN_gnt       out  1       high for the whole burst owned by N
//  rN_ack       out  1       high in each cycle a beat is executed for N
//  rN_rdata     out  DATA_W  read data, registered
//  rN_rvalid    out  1       rN_rdata valid; 1-cycle pulse per read beat
//  mem_addr     out  ADDR_W  to memory Address
//  mem_wdata    out  DATA_W  to memory Write_Data
//  mem_read     out  1       to memory read enable
//  mem_write    out  1       to memory write enable
//  mem_rdata    in   DATA_W  from memory Read_Data (combinational)
// BEHAVIOUR
//  Reset (rst=0 at posedge)
//   - State=IDLE; rr pointer=0 (port 0 favoured next).
//   - All outputs 0: gnt, ack, rvalid, rdata, mem_*.
//   - An in-flight burst is aborted; no further mem_write is issued.
//  IDLE
//   - mem_read=mem_write=0.
//   - Any rN_req=1 at a posedge selects the winner:
//     - only one requesting: that one wins;
//     - both requesting, PRIO_FIX=1: port 0 wins;
//     - both requesting, PRIO_FIX=0: the port named by rr wins.
//   - Latch winner id, we, addr with [1:0] forced to 00, and beat counter = len. Go to BUSY.
//   - rN_gnt rises in the cycle after the req is sampled (1-cycle arbitration latency).
//  BUSY (one beat per cycle, no wait states)
//   - mem_addr = latched address.
//   - mem_write = we; mem_wdata = winner's rN_wdata (combinational pass-through).
//   - mem_read = ~we.
//   - rN_ack=1 for the winner.
//   - Read beat: mem_rdata is captured into rN_rdata at the posedge; rN_rvalid=1 the following cycle.
//   - At each posedge: address += 4 (wraps modulo 2^ADDR_W); counter -= 1.
//   - When counter==0 at a posedge, the last beat is done:
//     - go to IDLE; gnt drops next cycle;
//     - rr = other port than the one just served (also updated when PRIO_FIX=1, but then unused).
//  Rules
//   - Requests are ignored during BUSY.
//   - Deasserting rN_req mid-burst does not shorten the burst.
//   - rN_we/addr/len need only be valid at the sampling edge.
//   - Loser holds req; it is served after the current burst plus one IDLE cycle.
//   - Minimum burst-to-burst gap: 1 IDLE cycle.
//   - Loser's gnt/ack/rvalid stay 0 throughout.
//   - The last read beat's rvalid appears in the first IDLE cycle.
//   - Outputs of the non-granted port are never glitched: gnt/ack are decoded from registered state.
// TESTING
//  1. Reset mid-burst:
//     - stimulus: rst=0 during beat 3 of a 16-beat write;
//     - response: next cycle all outputs 0, state IDLE, no later mem_write;
//     - check: memory words beyond beat 3 unchanged.
//  2. Single write:
//     - stimulus: r0 req, we=1, addr=0x10, len=0, wdata=0xDEADBEEF;
//     - response: gnt0 one cycle later, ack0 for 1 cycle with mem_write=1, mem_addr=0x10;
//     - check: a read back returns 0xDEADBEEF.
//  3. Read burst:
//     - stimulus: r1 req, we=0, addr=0x3FE (low bits dropped), len=3;
//     - response: mem_addr 0x3FC, 0x400, 0x404, 0x408 on consecutive cycles;
//     - response: 4 rvalid1 pulses, each 1 cycle after its beat.
//  4. Contention, PRIO_FIX=0, both req at same edge after reset:
//     - port 0 served first, port 1 next after 1 IDLE cycle;
//     - repeated simultaneous requests alternate 0,1,0,1.
//  5. PRIO_FIX=1, both continuously requesting:
//     - port 0 wins every arbitration;
//     - port 1 is granted only in an IDLE cycle where r0_req=0.
//  6. Address wrap:
//     - stimulus: addr=0xFFFFFFFC, len=1;
//     - response: beats at 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
//   One requester channel of the data-memory arbiter. The arbiter takes one
//   instance per requester (MEM stage, DMA/debug master).
//
//   Signals
//     req    requester -> arbiter  request; sampled only while the arbiter is idle
//     we     requester -> arbiter  1 = write burst, 0 = read burst
//     addr   requester -> arbiter  burst start byte address; bits [1:0] ignored
//     len    requester -> arbiter  burst length minus one
//     wdata  requester -> arbiter  write data for the beat currently acked
//     gnt    arbiter -> requester  high for the whole burst owned by this channel
//     ack    arbiter -> requester  high in each cycle a beat is executed
//     rdata  arbiter -> requester  registered read data
//     rvalid arbiter -> requester  one-cycle pulse per read beat, rdata valid
//
//   Modports
//     master  requester side
//     slave   arbiter side
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output req, we, addr, len, wdata,
        input  gnt, ack, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, len, wdata,
        output gnt, ack, rdata, rvalid
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter/sequencer in front of the single-port data memory.
//   Port r0 is the pipeline MEM stage, port r1 a DMA/debug master. A grant
//   covers a burst of len+1 word beats, one beat per cycle, with the beat
//   address stepping by 4. The memory is driven with a combinational-read /
//   posedge-write interface; read data comes back registered.
//
//   Parameters
//     DATA_W    memory word width
//     ADDR_W    byte address width
//     LEN_W     burst length field width (beats = len+1)
//     PRIO_FIX  0: round-robin between simultaneous requests
//               1: r0 always wins simultaneous requests
//
//   Ports
//     clk        clock, all state on posedge
//     rst        synchronous, active-low reset
//     r0, r1     requester channels (dmem_arbiter_if.slave)
//     mem_addr   memory address
//     mem_wdata  memory write data
//     mem_read   memory read enable
//     mem_write  memory write enable
//     mem_rdata  memory read data (combinational)
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 4,
    parameter bit PRIO_FIX = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     r0,
    dmem_arbiter_if.slave     r1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state,   state_nxt;
    logic              owner,   owner_nxt;   // 0 = r0, 1 = r1
    logic              we_q,    we_nxt;
    logic [ADDR_W-1:0] addr_q,  addr_nxt;
    logic [LEN_W-1:0]  cnt_q,   cnt_nxt;     // beats remaining after the current one
    logic              rr_q,    rr_nxt;      // port favoured on the next tie

    logic              busy;
    logic              rd_beat0;
    logic              rd_beat1;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              rvalid0_q, rvalid1_q;

    // ------------------------------------------------------------------
    // Next-state / burst bookkeeping
    // ------------------------------------------------------------------
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt_q;
        rr_nxt    = rr_q;

        case (state)
            IDLE: begin
                if (r0.req || r1.req) begin
                    if (r0.req && r1.req)
                        owner_nxt = PRIO_FIX ? 1'b0 : rr_q;
                    else
                        owner_nxt = r1.req;

                    we_nxt    = owner_nxt ? r1.we : r0.we;
                    // Beats are whole words; the byte offset is dropped here once.
                    addr_nxt  = (owner_nxt ? r1.addr : r0.addr) & ~ADDR_W'(3);
                    cnt_nxt   = owner_nxt ? r1.len : r0.len;
                    state_nxt = BUSY;
                end
            end

            BUSY: begin
                addr_nxt = addr_q + ADDR_W'(4);
                if (cnt_q == '0) begin
                    state_nxt = IDLE;
                    rr_nxt    = ~owner;
                end else begin
                    cnt_nxt = cnt_q - LEN_W'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            rr_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            we_q   <= we_nxt;
            addr_q <= addr_nxt;
            cnt_q  <= cnt_nxt;
            rr_q   <= rr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Registered read return
    // ------------------------------------------------------------------
    assign busy     = (state == BUSY);
    assign rd_beat0 = busy && !we_q && !owner;
    assign rd_beat1 = busy && !we_q &&  owner;

    // NOTE: the read-data registers are reset too, because rdata is a visible
    // output that must read 0 after reset, not just a don't-care payload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= rd_beat0;
            rvalid1_q <= rd_beat1;
            if (rd_beat0) rdata0_q <= mem_rdata;
            if (rd_beat1) rdata1_q <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: grant/ack decoded from registered state only, so the idle
    // port never sees a combinational glitch. With no wait states every
    // granted cycle executes a beat, hence ack == gnt.
    // ------------------------------------------------------------------
    assign r0.gnt    = busy && !owner;
    assign r1.gnt    = busy &&  owner;
    assign r0.ack    = busy && !owner;
    assign r1.ack    = busy &&  owner;
    assign r0.rdata  = rdata0_q;
    assign r1.rdata  = rdata1_q;
    assign r0.rvalid = rvalid0_q;
    assign r1.rvalid = rvalid1_q;

    assign mem_addr  = busy ? addr_q : '0;
    assign mem_write = busy &&  we_q;
    assign mem_read  = busy && !we_q;
    assign mem_wdata = busy ? (owner ? r1.wdata : r0.wdata) : '0;

endmodule
